// File: rtl/sm_hex_display_pkg.sv
// Shared defaults and helpers for the sm_hex_display seven-segment scanner.
// Defaults here are the board build: 8 digits, 2^16-cycle digit slot, 64-cycle dead time.
package sm_hex_display_pkg;

  localparam int DEF_DIGITS       = 8;
  localparam int DEF_PRESCALE_W   = 16;
  localparam int DEF_BLANK_CYCLES = 64;

  typedef logic [1:0] state_t;

  // One counter serves both phases, so it must be wide enough for the longer one.
  function automatic int cnt_width(input int prescale_w, input int blank_cycles);
    int blank_w;
    blank_w = $clog2(blank_cycles);
    return (prescale_w > blank_w) ? prescale_w : blank_w;
  endfunction

endpackage

// File: rtl/sm_hex_to_seg.sv
// Combinational hex nibble to seven-segment decoder, active-high {g,f,e,d,c,b,a}.
module sm_hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/sm_hex_display.sv
// Multiplexed seven-segment scanner with per-frame data latch and inter-digit dead time.
// Define SM_CONFIG_HEX_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module sm_hex_display
  import sm_hex_display_pkg::*;
#(
  parameter int DIGITS         = DEF_DIGITS,
  parameter int PRESCALE_W     = DEF_PRESCALE_W,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] data,
  input  logic [7:0]  dotMask,
  output logic [7:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frameStart
);

  localparam int            CW         = cnt_width(PRESCALE_W, BLANK_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'((64'd1 << PRESCALE_W) - 64'd1);
  localparam logic [2:0]    LAST_IDX   = 3'(DIGITS - 1);

  localparam logic [7:0] AN_OFF  = AN_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BLANK = 2'd1;
  localparam state_t SHOW  = 2'd2;

  state_t        state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   data_q;
  logic [7:0]    dot_q;
  logic          latch;
  logic          lit;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic [7:0]    an_hi;
  logic [6:0]    seg_hi;
  logic          dp_hi;

  assign nibble = data_q[{idx, 2'b00} +: 4];

  sm_hex_to_seg u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef SM_CONFIG_HEX_LEADING_ZERO_BLANK_EN
  logic [7:0] blank_q;

  // Digit i is blanked when it and every more significant digit are zero.
  function automatic logic [7:0] lead_zero_mask(input logic [31:0] d);
    logic all_zero;
    all_zero       = 1'b1;
    lead_zero_mask = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero          = all_zero && (d[4*i +: 4] == 4'h0);
      lead_zero_mask[i] = all_zero;
    end
  endfunction

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (latch) begin
      blank_q <= lead_zero_mask(data);
    end
  end
`endif

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      data_q     <= '0;
      dot_q      <= '0;
      anodes     <= AN_OFF;
      segments   <= SEG_OFF;
      dp         <= DP_OFF;
      frameStart <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      if (latch) begin
        data_q <= data;
        dot_q  <= dotMask;
      end
      anodes     <= an_hi ^ AN_OFF;
      segments   <= seg_hi ^ SEG_OFF;
      dp         <= dp_hi ^ DP_OFF;
      frameStart <= latch;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + CW'(1);
    latch     = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          latch     = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == LAST_IDX) begin
              idx_nxt = '0;
              latch   = 1'b1;
            end else begin
              idx_nxt = idx + 3'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Lit output is recomputed each SHOW cycle; data_q and idx are stable there, so it holds.
  always_comb begin
    lit    = enable && (((state == BLANK) && (cnt == BLANK_LAST)) ||
                        ((state == SHOW) && (cnt != SHOW_LAST)));
    an_hi  = '0;
    seg_hi = '0;
    dp_hi  = 1'b0;
    if (lit) begin
      an_hi  = 8'd1 << idx;
      seg_hi = seg_dec;
      dp_hi  = dot_q[idx];
`ifdef SM_CONFIG_HEX_LEADING_ZERO_BLANK_EN
      if (blank_q[idx]) begin
        seg_hi = '0;
        if (!dot_q[idx]) an_hi = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sm_hex_display.sv
// Self-checking bench for sm_hex_display: directed checks plus randomized traffic
// compared every cycle against a frame/slot arithmetic model of the scanner.
module tb_sm_hex_display;

  localparam int FRAME  = 48;
  localparam int SLOT   = 6;
  localparam int BLANKS = 2;

  logic        clkIn   = 1'b0;
  logic        rst_n   = 1'b0;
  logic        enable  = 1'b0;
  logic [31:0] data    = 32'h0;
  logic [7:0]  dotMask = 8'h0;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        frameStart;

  int checkCount = 0;
  int passCount  = 0;

  bit          running  = 1'b0;
  int          t        = 0;
  logic [31:0] lat_data = 32'h0;
  logic [7:0]  lat_dot  = 8'h0;

  logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  sm_hex_display #(
    .DIGITS         (8),
    .PRESCALE_W     (2),
    .BLANK_CYCLES   (2),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clkIn      (clkIn),
    .rst_n      (rst_n),
    .enable     (enable),
    .data       (data),
    .dotMask    (dotMask),
    .anodes     (anodes),
    .segments   (segments),
    .dp         (dp),
    .frameStart (frameStart)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Model: cycles since enable was taken, split into 48-cycle frames of 6-cycle slots.
  task automatic modelUpdate();
    if (!rst_n) begin
      running = 1'b0;
      t       = 0;
    end else if (!enable) begin
      running = 1'b0;
    end else begin
      if (!running) begin
        running = 1'b1;
        t       = 0;
      end else begin
        t++;
      end
      if ((t % FRAME) == 0) begin
        lat_data = data;
        lat_dot  = dotMask;
      end
    end
  endtask

  task automatic checkAll();
    int         pos;
    int         dig;
    bit         on;
    logic [7:0] an_exp;
    logic [6:0] seg_exp;
    logic       dp_exp;
    logic       fs_exp;
    logic [3:0] nib;
    an_exp  = 8'hFF;
    seg_exp = 7'h7F;
    dp_exp  = 1'b1;
    fs_exp  = 1'b0;
    if (running) begin
      pos    = t % FRAME;
      dig    = pos / SLOT;
      on     = (pos % SLOT) >= BLANKS;
      fs_exp = (pos == 0);
      nib    = lat_data[4*dig +: 4];
      if (on) begin
        an_exp  = ~(8'd1 << dig);
        seg_exp = ~seg_table[nib];
        dp_exp  = ~lat_dot[dig];
`ifdef SM_CONFIG_HEX_LEADING_ZERO_BLANK_EN
        if ((dig > 0) && ((lat_data >> (4*dig)) == 32'd0)) begin
          seg_exp = 7'h7F;
          if (!lat_dot[dig]) an_exp = 8'hFF;
        end
`endif
      end
    end
    checkOutput("anodes", 32'(anodes), 32'(an_exp));
    checkOutput("segments", 32'(segments), 32'(seg_exp));
    checkOutput("dp", 32'(dp), 32'(dp_exp));
    checkOutput("frameStart", 32'(frameStart), 32'(fs_exp));
  endtask

  task automatic step();
    @(posedge clkIn);
    modelUpdate();
    @(negedge clkIn);
    checkAll();
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] d, input logic [7:0] dm,
                               input int cycles);
    enable  = en;
    data    = d;
    dotMask = dm;
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic runToPos(input int p);
    for (int k = 0; k < 200 && !(running && ((t % FRAME) == p)); k++) step();
    checkOutput("reach_pos", 32'(running && ((t % FRAME) == p)), 32'd1);
  endtask

  initial begin
    $display("[TB] sm_hex_display bench starting");

    applyStimulus(1'b0, 32'h0, 8'h0, 3);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 8'h0, 20);

    applyStimulus(1'b1, 32'h01234567, 8'h01, 1);
    checkOutput("first_frame_start", 32'(frameStart), 32'd1);
    applyStimulus(1'b1, 32'h01234567, 8'h01, 2);
    checkOutput("d0_anodes", 32'(anodes), 32'h0000_00FE);
    checkOutput("d0_segments", 32'(segments), 32'h0000_0078);
    checkOutput("d0_dp", 32'(dp), 32'd0);
    applyStimulus(1'b1, 32'h01234567, 8'h01, 6);
    checkOutput("d1_anodes", 32'(anodes), 32'h0000_00FD);
    checkOutput("d1_segments", 32'(segments), 32'h0000_0002);
    checkOutput("d1_dp", 32'(dp), 32'd1);
    applyStimulus(1'b1, 32'h01234567, 8'h01, 100);

    runToPos(20);
    data = 32'hFFFFFFFF;
    runToPos(26);
    checkOutput("no_tear_d4", 32'(segments), 32'h0000_0030);
    runToPos(2);
    checkOutput("new_frame_F", 32'(segments), 32'h0000_000E);
    applyStimulus(1'b1, 32'hFFFFFFFF, 8'h00, 50);

    runToPos(32);
    applyStimulus(1'b0, 32'h89ABCDEF, 8'h80, 1);
    checkOutput("drop_anodes", 32'(anodes), 32'h0000_00FF);
    applyStimulus(1'b0, 32'h89ABCDEF, 8'h80, 2);
    applyStimulus(1'b1, 32'h89ABCDEF, 8'h80, 1);
    checkOutput("reenable_fs", 32'(frameStart), 32'd1);
    applyStimulus(1'b1, 32'h89ABCDEF, 8'h80, 2);
    checkOutput("reenable_d0", 32'(anodes), 32'h0000_00FE);
    applyStimulus(1'b1, 32'h89ABCDEF, 8'h80, 60);

`ifdef SM_CONFIG_HEX_LEADING_ZERO_BLANK_EN
    applyStimulus(1'b0, 32'h000000A0, 8'h10, 1);
    applyStimulus(1'b1, 32'h000000A0, 8'h10, 27);
    checkOutput("lz_d4_anodes", 32'(anodes), 32'h0000_00EF);
    checkOutput("lz_d4_dp", 32'(dp), 32'd0);
    applyStimulus(1'b1, 32'h000000A0, 8'h10, 60);
`endif

    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 9) == 0) data = $urandom;
      if ($urandom_range(0, 9) == 0) dotMask = 8'($urandom);
      enable = ($urandom_range(0, 49) != 0);
      step();
    end

    enable = 1'b1;
    runToPos(4);
    @(posedge clkIn);
    modelUpdate();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_anodes", 32'(anodes), 32'h0000_00FF);
    checkOutput("async_segments", 32'(segments), 32'h0000_007F);
    checkOutput("async_dp", 32'(dp), 32'd1);
    checkOutput("async_fs", 32'(frameStart), 32'd0);
    modelUpdate();
    @(negedge clkIn);
    checkAll();
    applyStimulus(1'b1, 32'h13579BDF, 8'h5A, 2);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h13579BDF, 8'h5A, 1);
    checkOutput("post_reset_fs", 32'(frameStart), 32'd1);
    applyStimulus(1'b1, 32'h13579BDF, 8'h5A, 60);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
